// File: rtl/image_pixel_op.sv
// Streaming RGB point operation (pass/invert/gray/brightness/threshold) with frame markers.
// Latency 2 cycles; one global enable stalls the whole pipe while out_valid && !out_ready.
module image_pixel_op #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 512,
  parameter int HEIGHT     = 768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  sel_thr,
  input  logic [DATA_WIDTH:0]   offset,
  input  logic [DATA_WIDTH-1:0] thresh,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_g,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_g,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 2;
  localparam int GW = DATA_WIDTH + 8;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [DW-1:0] MAX = '1;

  function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] c);
    return $signed({2'b00, c});
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] v);
    if (v[SW-1])  return '0;
    else if (v[DW]) return MAX;
    else          return v[DW-1:0];
  endfunction

  logic              en, in_xfer, first, eol, eof;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [1:0]        mode_q, m_eff;
  logic              sel_q, s_eff;
  logic [DW:0]       off_q, o_eff;
  logic [DW-1:0]     thr_q, t_eff;
  logic [GW-1:0]     gray_sum;
  logic [DW-1:0]     gray_y;
  logic signed [SW-1:0] c_r, c_g, c_b, off_s;
  logic              s1_vld_q, s2_vld_q;
  logic signed [SW-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic [2:0]        s1_flg_q, s2_flg_q;
  logic [DW-1:0]     s2_r_q, s2_g_q, s2_b_q;

  assign en       = !s2_vld_q || out_ready;
  assign in_ready = en;
  assign in_xfer  = in_valid && en;
  assign first    = (x_q == '0) && (y_q == '0);
  assign eol      = (x_q == XW'(WIDTH - 1));
  assign eof      = eol && (y_q == YW'(HEIGHT - 1));

  // The frame's first pixel uses the live config; the rest of the frame uses the latched copy.
  assign m_eff = first ? mode    : mode_q;
  assign s_eff = first ? sel_thr : sel_q;
  assign o_eff = first ? offset  : off_q;
  assign t_eff = first ? thresh  : thr_q;

  assign gray_sum = GW'(77) * GW'(in_r) + GW'(150) * GW'(in_g) + GW'(29) * GW'(in_b);
  assign gray_y   = DW'(gray_sum >> 8);
  assign off_s    = $signed({o_eff[DW], o_eff});

  always_comb begin
    c_r = ext(in_r);
    c_g = ext(in_g);
    c_b = ext(in_b);
    unique case (m_eff)
      2'b00: ;
      2'b01: begin
        c_r = ext(MAX - in_r);
        c_g = ext(MAX - in_g);
        c_b = ext(MAX - in_b);
      end
      2'b10: begin
        c_r = ext(gray_y);
        c_g = ext(gray_y);
        c_b = ext(gray_y);
      end
      default: begin
        if (s_eff) begin
          c_r = ext((gray_y >= t_eff) ? MAX : '0);
          c_g = c_r;
          c_b = c_r;
        end else begin
          c_r = ext(in_r) + off_s;
          c_g = ext(in_g) + off_s;
          c_b = ext(in_b) + off_s;
        end
      end
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_xfer) begin
      if (eol) begin
        x_d = '0;
        y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 2'b00;
      sel_q    <= 1'b0;
      off_q    <= '0;
      thr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_r_q   <= '0;
      s1_g_q   <= '0;
      s1_b_q   <= '0;
      s1_flg_q <= '0;
      s2_vld_q <= 1'b0;
      s2_r_q   <= '0;
      s2_g_q   <= '0;
      s2_b_q   <= '0;
      s2_flg_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (in_xfer && first) begin
        mode_q <= mode;
        sel_q  <= sel_thr;
        off_q  <= offset;
        thr_q  <= thresh;
      end
      if (en) begin
        s1_vld_q <= in_xfer;
        s1_r_q   <= c_r;
        s1_g_q   <= c_g;
        s1_b_q   <= c_b;
        s1_flg_q <= in_xfer ? {first, eol, eof} : 3'b000;
        s2_vld_q <= s1_vld_q;
        s2_r_q   <= clamp(s1_r_q);
        s2_g_q   <= clamp(s1_g_q);
        s2_b_q   <= clamp(s1_b_q);
        s2_flg_q <= s1_vld_q ? s1_flg_q : 3'b000;
      end
    end
  end

  assign out_valid = s2_vld_q;
  assign out_r     = s2_r_q;
  assign out_g     = s2_g_q;
  assign out_b     = s2_b_q;
  assign {out_sof, out_eol, out_eof} = s2_flg_q;
endmodule

// File: tb/tb_image_pixel_op.sv
// Directed bench for image_pixel_op with a 4x2 frame.
module tb_image_pixel_op;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          sel_thr;
  logic [DW:0]   offset;
  logic [DW-1:0] thresh;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_r, in_g, in_b, out_r, out_g, out_b;
  logic          out_sof, out_eol, out_eof;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  image_pixel_op #(.DATA_WIDTH(DW), .WIDTH(4), .HEIGHT(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel_thr(sel_thr), .offset(offset), .thresh(thresh),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  typedef struct {
    logic [1:0] m;
    logic       s;
    logic [8:0] off;
    logic [7:0] thr;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pr(input int i, input int f); return 8'(i * 17 + f * 3); endfunction
  function automatic logic [7:0] pg(input int i, input int f); return 8'(i * 5 + 40 + f);  endfunction
  function automatic logic [7:0] pb(input int i, input int f); return 8'(200 - i * 7 - f); endfunction

  function automatic logic [26:0] frame_exp(input int n);
    int f, i;
    logic [7:0] r, g, b;
    f = n / 8;
    i = n % 8;
    r = pr(i, f); g = pg(i, f); b = pb(i, f);
    if (f == 0) begin r = 8'd255 - r; g = 8'd255 - g; b = 8'd255 - b; end
    return {r, g, b, (i == 0), (i == 3 || i == 7), (i == 7)};
  endfunction

  initial begin
    int sent, got, cyc;
    logic held;
    logic [27:0] hv;

    vt[0] = '{2'b01, 1'b0, 9'd0,     8'd0,   8'd10,  8'd20,  8'd30,  8'd245, 8'd235, 8'd225};
    vt[1] = '{2'b01, 1'b0, 9'd0,     8'd0,   8'd255, 8'd0,   8'd128, 8'd0,   8'd255, 8'd127};
    vt[2] = '{2'b10, 1'b0, 9'd0,     8'd0,   8'd255, 8'd0,   8'd0,   8'd76,  8'd76,  8'd76};
    vt[3] = '{2'b10, 1'b0, 9'd0,     8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    vt[4] = '{2'b10, 1'b0, 9'd0,     8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    vt[5] = '{2'b11, 1'b0, 9'd50,    8'd0,   8'd220, 8'd10,  8'd0,   8'd255, 8'd60,  8'd50};
    vt[6] = '{2'b11, 1'b0, 9'h1EC,   8'd0,   8'd10,  8'd30,  8'd255, 8'd0,   8'd10,  8'd235};
    vt[7] = '{2'b11, 1'b1, 9'd0,     8'd128, 8'd128, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
    vt[8] = '{2'b11, 1'b1, 9'd0,     8'd128, 8'd127, 8'd127, 8'd127, 8'd0,   8'd0,   8'd0};
    vt[9] = '{2'b00, 1'b0, 9'd0,     8'd0,   8'd1,   8'd2,   8'd3,   8'd1,   8'd2,   8'd3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; sel_thr = 1'b0; offset = '0; thresh = '0;
    in_r = '0; in_g = '0; in_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_rgb", {out_r, out_g, out_b}, 0);
    chk("reset_flags", {out_sof, out_eol, out_eof}, 0);
    chk("reset_in_ready", in_ready, 1);

    // Single-pixel vectors, each starting a fresh frame so its config is sampled.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      mode = vt[i].m; sel_thr = vt[i].s; offset = vt[i].off; thresh = vt[i].thr;
      in_r = vt[i].r; in_g = vt[i].g; in_b = vt[i].b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1_valid", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_rgb", i), {out_r, out_g, out_b}, {vt[i].er, vt[i].eg, vt[i].eb});
      chk($sformatf("vec%0d_flags", i), {out_sof, out_eol, out_eof}, 3'b100);
    end

    // Back-to-back invert pair: 2-cycle latency at full throughput.
    do_reset();
    mode = 2'b01; out_ready = 1'b1;
    in_r = 8'd10; in_g = 8'd20; in_b = 8'd30; in_valid = 1'b1;
    @(negedge clk);
    in_r = 8'd255; in_g = 8'd0; in_b = 8'd128;
    chk("pair_lat1", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pair_a", {out_valid, out_r, out_g, out_b}, {1'b1, 8'd245, 8'd235, 8'd225});
    @(negedge clk);
    chk("pair_b", {out_valid, out_r, out_g, out_b}, {1'b1, 8'd0, 8'd255, 8'd127});
    @(negedge clk);
    chk("pair_drain", out_valid, 0);

    // Two frames with random backpressure; mode switches to pass at pixel 3 of frame 0.
    do_reset();
    mode = 2'b01; sel_thr = 1'b0;
    sent = 0; got = 0; cyc = 0; held = 1'b0; hv = '0;
    while (got < 16 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (held)
        chk("stall_hold", {out_valid, out_r, out_g, out_b, out_sof, out_eol, out_eof}, hv);
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 16) begin
        if (sent == 3) mode = 2'b00;
        in_valid = 1'b1;
        in_r = pr(sent % 8, sent / 8); in_g = pg(sent % 8, sent / 8); in_b = pb(sent % 8, sent / 8);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) sent++;
      held = out_valid && !out_ready;
      if (held) hv = {out_valid, out_r, out_g, out_b, out_sof, out_eol, out_eof};
      if (out_valid && out_ready) begin
        chk($sformatf("frame_px%0d", got), {out_r, out_g, out_b, out_sof, out_eol, out_eof},
            frame_exp(got));
        got++;
      end
    end
    if (got < 16) chk("frame_timeout", got, 16);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset after pixel 5 of a frame.
    do_reset();
    mode = 2'b00; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_r = 8'(i); in_g = 8'(i); in_b = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    in_valid = 1'b1; in_r = 8'd99; in_g = 8'd98; in_b = 8'd97;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_px", {out_valid, out_r, out_g, out_b}, {1'b1, 8'd99, 8'd98, 8'd97});
    chk("midrst_flags", {out_sof, out_eol, out_eof}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
